// File: rtl/dds_pkg.sv
// dds_pkg: shared key polarity and debounce length constants for the DDS control panel.
package dds_pkg;
  localparam logic KEY_PRESSED = 1'b0;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 200;
  localparam int HW_DEBOUNCE_CYCLES = 1_000_000;
endpackage

// File: rtl/key_handle_if.sv
// key_handle_if: raw panel keys in, debounced strobes and waveform level out.
interface key_handle_if;
  logic key_freq_add;
  logic key_freq_sub;
  logic key_a;
  logic key_wave;
  logic wave_flag;
  logic key_freq_add_flag;
  logic key_freq_sub_flag;
  logic key_a_flag;
  modport master (
    output key_freq_add, key_freq_sub, key_a, key_wave,
    input  wave_flag, key_freq_add_flag, key_freq_sub_flag, key_a_flag
  );
  modport slave (
    input  key_freq_add, key_freq_sub, key_a, key_wave,
    output wave_flag, key_freq_add_flag, key_freq_sub_flag, key_a_flag
  );
endinterface

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchronizer plus hold counter for one active-low key.
// o_press_pulse is combinational and is high the cycle before the edge that accepts a press.
module key_debounce
  import dds_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key,
  output logic o_press_pulse
);
  localparam int W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(DEBOUNCE_CYCLES - 1);
  logic r_s1, r_s2, r_stable;
  logic [W-1:0] r_cnt;
  logic w_diff, w_accept;
  assign w_diff = r_s2 != r_stable;
  assign w_accept = w_diff && r_cnt == LAST;
  assign o_press_pulse = w_accept && r_s2 == KEY_PRESSED;
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_stable <= 1'b1;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_key;
      r_s2 <= r_s1;
      r_cnt <= (w_diff && !w_accept) ? r_cnt + W'(1) : '0;
      if (w_accept) r_stable <= r_s2;
    end
  end
endmodule

// File: rtl/key_handle.sv
// key_handle: debounces four panel keys into press strobes and a waveform toggle level.
// rst_n is an active-high asynchronous reset despite its name.
module key_handle
  import dds_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic         clk,
  input  logic         rst_n,
  key_handle_if.slave  bus
);
  logic [3:0] w_keys, w_press;
  logic r_add, r_sub, r_a, r_wave;
  assign w_keys = {bus.key_wave, bus.key_a, bus.key_freq_sub, bus.key_freq_add};
  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk(clk),
      .rst_n(rst_n),
      .i_key(w_keys[i]),
      .o_press_pulse(w_press[i])
    );
  end
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_add <= 1'b0;
      r_sub <= 1'b0;
      r_a <= 1'b0;
      r_wave <= 1'b0;
    end else begin
      r_add <= w_press[0];
      r_sub <= w_press[1];
      r_a <= w_press[2];
      r_wave <= r_wave ^ w_press[3];
    end
  end
  assign bus.key_freq_add_flag = r_add;
  assign bus.key_freq_sub_flag = r_sub;
  assign bus.key_a_flag = r_a;
  assign bus.wave_flag = r_wave;
endmodule

// File: tb/tb_key_handle.sv
// tb_key_handle: directed tests of key_handle with DEBOUNCE_CYCLES=200 and a 20 ns clock.
module tb_key_handle;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int edge_n;
  int pc[4];
  int fe[4];
  int wchg, wfirst;
  logic wprev;

  key_handle_if bus();
  key_handle #(.DEBOUNCE_CYCLES(200)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #10 clk = ~clk;

  function automatic logic flag(input int k);
    return k == 0 ? bus.key_freq_add_flag : k == 1 ? bus.key_freq_sub_flag : bus.key_a_flag;
  endfunction

  task automatic set_key(input int k, input logic v);
    case (k)
      0: bus.key_freq_add = v;
      1: bus.key_freq_sub = v;
      2: bus.key_a = v;
      default: bus.key_wave = v;
    endcase
  endtask

  task automatic clear_mon();
    edge_n = 0;
    for (int k = 0; k < 4; k++) begin
      pc[k] = 0;
      fe[k] = -1;
    end
    wchg = 0;
    wfirst = -1;
    wprev = bus.wave_flag;
  endtask

  // advance n edges, sampling 1 ns after each rising edge
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      edge_n++;
      for (int k = 0; k < 3; k++)
        if (flag(k) === 1'b1) begin
          pc[k]++;
          if (fe[k] < 0) fe[k] = edge_n;
        end
      if (bus.wave_flag !== wprev) begin
        wchg++;
        if (wfirst < 0) wfirst = edge_n;
        wprev = bus.wave_flag;
      end
    end
  endtask

  task automatic test_reset();
    bus.key_freq_add = 1'b1;
    bus.key_freq_sub = 1'b1;
    bus.key_a = 1'b1;
    bus.key_wave = 1'b1;
    #2 rst_n = 1'b1;
    #3;
    vectors++;
    if ({bus.wave_flag, bus.key_freq_add_flag, bus.key_freq_sub_flag, bus.key_a_flag} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_async flags=%b required=0000",
        {bus.wave_flag, bus.key_freq_add_flag, bus.key_freq_sub_flag, bus.key_a_flag});
    end
    run(4);
    rst_n = 1'b0;
    clear_mon();
    run(300);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (pc[k] !== 0) begin
        miscompares++;
        $display("FAIL idle_pulses k=%0d got=%0d required=0", k, pc[k]);
      end
    end
    vectors++;
    if (bus.wave_flag !== 1'b0 || wchg !== 0) begin
      miscompares++;
      $display("FAIL idle_wave got=%b changes=%0d required=0/0", bus.wave_flag, wchg);
    end
  endtask

  task automatic test_wave();
    set_key(3, 1'b0);
    clear_mon();
    run(275);
    vectors++;
    if (wfirst !== 202 || wchg !== 1 || bus.wave_flag !== 1'b1) begin
      miscompares++;
      $display("FAIL wave_toggle1 edge=%0d changes=%0d level=%b required=202/1/1", wfirst, wchg, bus.wave_flag);
    end
    vectors++;
    if (pc[0] + pc[1] + pc[2] !== 0) begin
      miscompares++;
      $display("FAIL wave_other_flags got=%0d required=0", pc[0] + pc[1] + pc[2]);
    end
    set_key(3, 1'b1);
    clear_mon();
    run(210);
    vectors++;
    if (wchg !== 0 || bus.wave_flag !== 1'b1) begin
      miscompares++;
      $display("FAIL wave_release changes=%0d level=%b required=0/1", wchg, bus.wave_flag);
    end
    set_key(3, 1'b0);
    clear_mon();
    run(250);
    vectors++;
    if (wfirst !== 202 || wchg !== 1 || bus.wave_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL wave_toggle2 edge=%0d changes=%0d level=%b required=202/1/0", wfirst, wchg, bus.wave_flag);
    end
    set_key(3, 1'b1);
    run(250);
  endtask

  task automatic test_single_pulses();
    int order[3] = '{2, 1, 0};
    int hold[3] = '{300, 280, 300};
    for (int i = 0; i < 3; i++) begin
      set_key(order[i], 1'b0);
      clear_mon();
      run(hold[i]);
      vectors++;
      if (fe[order[i]] !== 202 || pc[order[i]] !== 1) begin
        miscompares++;
        $display("FAIL press_pulse k=%0d edge=%0d count=%0d required=202/1", order[i], fe[order[i]], pc[order[i]]);
      end
      vectors++;
      if (pc[0] + pc[1] + pc[2] !== 1 || wchg !== 0) begin
        miscompares++;
        $display("FAIL press_cross k=%0d total=%0d wave_changes=%0d required=1/0", order[i], pc[0] + pc[1] + pc[2], wchg);
      end
      set_key(order[i], 1'b1);
      clear_mon();
      run(250);
      vectors++;
      if (pc[order[i]] !== 0) begin
        miscompares++;
        $display("FAIL release_pulse k=%0d got=%0d required=0", order[i], pc[order[i]]);
      end
    end
  endtask

  task automatic test_glitch();
    clear_mon();
    repeat (5) begin
      set_key(0, 1'b0);
      run(150);
      set_key(0, 1'b1);
      run(10);
    end
    vectors++;
    if (pc[0] !== 0) begin
      miscompares++;
      $display("FAIL glitch_rejected got=%0d required=0", pc[0]);
    end
    set_key(0, 1'b0);
    clear_mon();
    run(250);
    vectors++;
    if (fe[0] !== 202 || pc[0] !== 1) begin
      miscompares++;
      $display("FAIL glitch_then_hold edge=%0d count=%0d required=202/1", fe[0], pc[0]);
    end
    set_key(0, 1'b1);
    run(250);
  endtask

  task automatic test_simultaneous();
    set_key(2, 1'b0);
    set_key(1, 1'b0);
    clear_mon();
    run(250);
    vectors++;
    if (fe[2] !== 202 || fe[1] !== 202 || pc[2] !== 1 || pc[1] !== 1) begin
      miscompares++;
      $display("FAIL simultaneous a=%0d/%0d sub=%0d/%0d required=202/1 each", fe[2], pc[2], fe[1], pc[1]);
    end
    vectors++;
    if (wchg !== 0 || bus.wave_flag !== 1'b0 || pc[0] !== 0) begin
      miscompares++;
      $display("FAIL simultaneous_others wave_changes=%0d wave=%b add=%0d required=0/0/0", wchg, bus.wave_flag, pc[0]);
    end
    set_key(2, 1'b1);
    set_key(1, 1'b1);
    run(250);
  endtask

  task automatic test_reset_mid();
    set_key(2, 1'b0);
    clear_mon();
    run(100);
    rst_n = 1'b1;
    run(3);
    vectors++;
    if (pc[2] !== 0 || bus.key_a_flag !== 1'b0 || bus.wave_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_hold pulses=%0d flag=%b wave=%b required=0/0/0", pc[2], bus.key_a_flag, bus.wave_flag);
    end
    rst_n = 1'b0;
    clear_mon();
    run(250);
    vectors++;
    if (fe[2] !== 202 || pc[2] !== 1) begin
      miscompares++;
      $display("FAIL reset_mid_recount edge=%0d count=%0d required=202/1", fe[2], pc[2]);
    end
    set_key(2, 1'b1);
    run(250);
  endtask

  initial begin
    test_reset();
    test_wave();
    test_single_pulses();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
